sw_evt_master: RTL and testbench

Avalon-MM master that services the 4-bit switch PIO slave (edge-capture input port with level-sensitive IRQ). On IRQ, or on a poll tick when enabled, it reads the edge-capture and data registers, clears edge-capture, and queues a {capture, level} event in an internal FIFO. Downstream logic drains the FIFO over a valid/ready stream. The block sits between the switch PIO and fabric logic that must react to switch changes without a CPU.

---
 rtl/sw_evt_pkg.sv | 17 +
 rtl/sw_evt_fifo.sv | 71 +++++++
 rtl/sw_evt_master.sv | 189 ++++++++++++++++++
 tb/tb_sw_evt_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sw_evt_pkg.sv
// Shared types and PIO register map for the switch-event Avalon master.
package sw_evt_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_CAP  = 3'd2,
    ST_DAT  = 3'd3,
    ST_CLR  = 3'd4,
    ST_PUSH = 3'd5
  } sw_evt_state_t;

  localparam logic [1:0] SW_ADDR_DATA = 2'd0;
  localparam logic [1:0] SW_ADDR_MASK = 2'd2;
  localparam logic [1:0] SW_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/sw_evt_fifo.sv
// Synchronous event FIFO with registered head/valid outputs and same-cycle push/pop.
module sw_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_s;
  logic             pop_s;
  logic             push_s;
  logic [WIDTH-1:0] head_s;

  // Accept/drop decisions and the next head value
  always_comb begin
    pop_s   = pop && (count_r != '0);
    full    = (count_r == CW'(DEPTH));
    push_s  = push && (!full || pop_s);
    dropped = push && !push_s;
    count_s = count_r + CW'(push_s) - CW'(pop_s);
    head_s  = head;
    if (count_s == '0) begin
      head_s = '0;
    end else if (pop_s) begin
      // Popping the last entry while pushing hands the new entry straight to the head
      head_s = (count_r == CW'(1)) ? push_data : mem_r[rd_ptr_r + AW'(1)];
    end else if (count_r == '0) begin
      head_s = push_data;
    end else begin
      head_s = head;
    end
  end

  // Pointer, occupancy and head registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      head     <= '0;
      valid    <= 1'b0;
    end else begin
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      count_r <= count_s;
      head    <= head_s;
      valid   <= (count_s != '0);
    end
  end

  // Storage array; contents are meaningless until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/sw_evt_master.sv
// Avalon-MM master servicing the switch PIO and queuing {capture, level} events.
// Optional periodic polling is enabled by defining SW_EVT_POLL_EN.
module sw_evt_master #(
  parameter int                DATA_W      = 4,
  parameter logic [DATA_W-1:0] IRQ_MASK    = {DATA_W{1'b1}},
  parameter int                FIFO_DEPTH  = 8,
  parameter int                POLL_PERIOD = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [1:0]          avm_address,
  output logic                avm_chipselect,
  output logic                avm_write_n,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                pio_irq,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [2*DATA_W-1:0] evt_data,
  output logic                evt_overflow,
  input  logic                ovf_clr,
  output logic                busy
);

  import sw_evt_pkg::*;

  sw_evt_state_t     state_r;
  sw_evt_state_t     next_state_s;
  logic              init_sent_r;
  logic [DATA_W-1:0] cap_r;
  logic [DATA_W-1:0] lvl_r;
  logic [1:0]        addr_s;
  logic              cs_s;
  logic              wn_s;
  logic [DATA_W-1:0] wd_s;
  logic              trigger_s;
  logic              push_s;
  logic              drop_s;
  logic              fifo_full_s;

`ifdef SW_EVT_POLL_EN
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  logic [PW-1:0] poll_cnt_r;
  logic          poll_pend_r;

  // Poll request generator; the request is held until IDLE consumes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt_r  <= '0;
      poll_pend_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && trigger_s) begin
      poll_cnt_r  <= '0;
      poll_pend_r <= 1'b0;
    end else if (poll_pend_r) begin
      poll_cnt_r  <= poll_cnt_r;
    end else if (poll_cnt_r == PW'(POLL_PERIOD - 1)) begin
      poll_pend_r <= 1'b1;
    end else begin
      poll_cnt_r  <= poll_cnt_r + PW'(1);
    end
  end

  assign trigger_s = pio_irq | poll_pend_r;
`else
  logic unused_poll_s;
  assign unused_poll_s = (POLL_PERIOD > 0);
  assign trigger_s     = pio_irq;
`endif

  // State register; init_sent_r marks the second INIT cycle, when the mask write is on the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_INIT;
      init_sent_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      init_sent_r <= (state_r == ST_INIT);
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_INIT: next_state_s = init_sent_r ? ST_IDLE : ST_INIT;
      ST_IDLE: next_state_s = trigger_s ? ST_CAP : ST_IDLE;
      ST_CAP:  next_state_s = ST_DAT;
      ST_DAT:  next_state_s = ST_CLR;
      ST_CLR:  next_state_s = ST_PUSH;
      ST_PUSH: next_state_s = ST_IDLE;
      default: next_state_s = ST_INIT;
    endcase
  end

  // Bus values for the state being entered, so the access is on the bus during that state
  always_comb begin
    addr_s = SW_ADDR_DATA;
    cs_s   = 1'b0;
    wn_s   = 1'b1;
    wd_s   = '0;
    case (next_state_s)
      ST_INIT: begin
        addr_s = SW_ADDR_MASK;
        cs_s   = 1'b1;
        wn_s   = 1'b0;
        wd_s   = IRQ_MASK;
      end
      ST_CAP: begin
        addr_s = SW_ADDR_EDGE;
        cs_s   = 1'b1;
      end
      ST_DAT: begin
        addr_s = SW_ADDR_DATA;
        cs_s   = 1'b1;
      end
      ST_CLR: begin
        addr_s = SW_ADDR_EDGE;
        cs_s   = 1'b1;
        wn_s   = 1'b0;
      end
      default: begin
        addr_s = SW_ADDR_DATA;
        cs_s   = 1'b0;
      end
    endcase
  end

  // Registered bus and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_address    <= SW_ADDR_DATA;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      busy           <= 1'b0;
    end else begin
      avm_address    <= addr_s;
      avm_chipselect <= cs_s;
      avm_write_n    <= wn_s;
      avm_writedata  <= wd_s;
      busy           <= (next_state_s != ST_IDLE);
    end
  end

  // Read data lags the address by one cycle: DAT sees the edge read, CLR sees the data read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_r <= '0;
      lvl_r <= '0;
    end else begin
      if (state_r == ST_DAT) cap_r <= avm_readdata;
      if (state_r == ST_CLR) lvl_r <= avm_readdata;
    end
  end

  assign push_s = (state_r == ST_PUSH) && (cap_r != '0);

  // Sticky overflow; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_overflow <= 1'b0;
    end else if (drop_s) begin
      evt_overflow <= 1'b1;
    end else if (ovf_clr) begin
      evt_overflow <= 1'b0;
    end else begin
      evt_overflow <= evt_overflow;
    end
  end

  sw_evt_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data ({cap_r, lvl_r}),
    .pop       (evt_ready),
    .head      (evt_data),
    .valid     (evt_valid),
    .full      (fifo_full_s),
    .dropped   (drop_s)
  );

  logic unused_full_s;
  assign unused_full_s = fifo_full_s;

endmodule

// File: tb/tb_sw_evt_master.sv
// Scoreboard bench for sw_evt_master with a behavioural switch PIO slave.
module tb_sw_evt_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] avm_address;
  logic       avm_chipselect;
  logic       avm_write_n;
  logic [3:0] avm_writedata;
  logic [3:0] avm_readdata;
  logic       pio_irq;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_data;
  logic       evt_overflow;
  logic       ovf_clr = 1'b0;
  logic       busy;

  logic [3:0] edge_reg;
  logic [3:0] mask_reg;
  logic [3:0] sw_level = 4'h0;
  logic [3:0] edge_set = 4'h0;
  logic       force_irq = 1'b0;

  int         checks = 0;
  int         failures = 0;
  bit         stim_done = 1'b0;
  int         w2_cnt = 0;
  int         w3_cnt = 0;
  int         r3_cnt = 0;
  logic [3:0] last_w2 = 4'h0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sw_evt_master #(
    .DATA_W      (4),
    .IRQ_MASK    (4'hF),
    .FIFO_DEPTH  (8),
    .POLL_PERIOD (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .pio_irq        (pio_irq),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .evt_overflow   (evt_overflow),
    .ovf_clr        (ovf_clr),
    .busy           (busy)
  );

  // PIO slave model: registered read data, edge capture cleared by any write to address 3
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_reg     <= 4'h0;
      mask_reg     <= 4'h0;
      avm_readdata <= 4'h0;
    end else begin
      if (avm_chipselect && !avm_write_n && avm_address == 2'd3) edge_reg <= 4'h0;
      else edge_reg <= edge_reg | edge_set;
      if (avm_chipselect && !avm_write_n && avm_address == 2'd2) mask_reg <= avm_writedata;
      if (avm_chipselect) begin
        case (avm_address)
          2'd0:    avm_readdata <= sw_level;
          2'd2:    avm_readdata <= mask_reg;
          2'd3:    avm_readdata <= edge_reg;
          default: avm_readdata <= 4'h0;
        endcase
      end
    end
  end

  assign pio_irq = (|(edge_reg & mask_reg)) | force_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One PIO service: edge lands at the next edge, PUSH is four cycles later
  task automatic svc(input logic [3:0] cap, input logic [3:0] lvl, input bit expect_push,
                     input bit ready_in_push, input bit chk_lat);
    sw_level = lvl;
    if (expect_push) exp_q.push_back({cap, lvl});
    edge_set = cap;
    tick();
    edge_set = 4'h0;
    tick(); tick(); tick(); tick();
    if (chk_lat) chk("valid_before_latency", 32'(evt_valid), 32'(0));
    if (ready_in_push) evt_ready = 1'b1;
    tick();
    if (ready_in_push) evt_ready = 1'b0;
    if (chk_lat) chk("valid_at_latency", 32'(evt_valid), 32'(1));
    tick();
  endtask

  initial begin
    fork
      begin : stim
        int         w2_before;
        int         r3_before;
        logic [3:0] c;
        logic [3:0] l;
        tick(); tick(); tick();
        chk("rst_address", 32'(avm_address), 32'(0));
        chk("rst_chipselect", 32'(avm_chipselect), 32'(0));
        chk("rst_write_n", 32'(avm_write_n), 32'(1));
        chk("rst_writedata", 32'(avm_writedata), 32'(0));
        chk("rst_evt_valid", 32'(evt_valid), 32'(0));
        chk("rst_evt_data", 32'(evt_data), 32'(0));
        chk("rst_overflow", 32'(evt_overflow), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        reset_n = 1'b1;
        repeat (6) tick();
        chk("init_write_count", 32'(w2_cnt), 32'(1));
        chk("init_write_data", 32'(last_w2), 32'(4'hF));
        chk("init_bus_idle", 32'(avm_chipselect), 32'(0));
        chk("init_busy", 32'(busy), 32'(0));
`ifdef SW_EVT_POLL_EN
        r3_before = r3_cnt;
        repeat (100) tick();
        chk("poll_reads_min", 32'((r3_cnt - r3_before) >= 5), 32'(1));
        chk("poll_reads_max", 32'((r3_cnt - r3_before) <= 7), 32'(1));
        chk("poll_no_event", 32'(evt_valid), 32'(0));
`else
        // basic service with consumer ready
        evt_ready = 1'b1;
        svc(4'b0010, 4'b1010, 1'b1, 1'b0, 1'b1);
        tick();
        chk("one_edge_clear", 32'(w3_cnt), 32'(1));
        chk("drained_1", 32'(exp_q.size()), 32'(0));

        // spurious trigger: capture reads 0
        force_irq = 1'b1;
        tick();
        force_irq = 1'b0;
        tick(); tick();
        chk("spur_busy_mid", 32'(busy), 32'(1));
        tick(); tick();
        chk("spur_busy_done", 32'(busy), 32'(0));
        chk("spur_no_event", 32'(evt_valid), 32'(0));

        // fill past capacity with consumer stalled
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
          c = 4'(i + 1);
          l = 4'(14 - i);
          svc(c, l, (i < 8), 1'b0, 1'b0);
          if (i == 7) chk("ovf_at_full", 32'(evt_overflow), 32'(0));
        end
        chk("ovf_after_drop", 32'(evt_overflow), 32'(1));
        tick(); tick(); tick();
        chk("head_hold", 32'(evt_data), 32'(8'h1E));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(evt_overflow), 32'(0));

        // full FIFO, pop in the PUSH cycle accepts the push
        svc(4'hC, 4'h3, 1'b1, 1'b1, 1'b0);
        chk("ovf_push_with_pop", 32'(evt_overflow), 32'(0));
        evt_ready = 1'b1;
        repeat (10) tick();
        chk("drained_all", 32'(exp_q.size()), 32'(0));
        chk("empty_after_drain", 32'(evt_valid), 32'(0));

        // reset during CLR with one entry queued
        evt_ready = 1'b0;
        svc(4'h3, 4'h7, 1'b1, 1'b0, 1'b0);
        w2_before = w2_cnt;
        edge_set = 4'h5;
        tick();
        edge_set = 4'h0;
        tick(); tick(); tick();
        chk("mid_service_busy", 32'(busy), 32'(1));
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mrst_chipselect", 32'(avm_chipselect), 32'(0));
        chk("mrst_write_n", 32'(avm_write_n), 32'(1));
        chk("mrst_address", 32'(avm_address), 32'(0));
        chk("mrst_evt_valid", 32'(evt_valid), 32'(0));
        chk("mrst_evt_data", 32'(evt_data), 32'(0));
        chk("mrst_busy", 32'(busy), 32'(0));
        tick(); tick();
        reset_n = 1'b1;
        repeat (6) tick();
        chk("reinit_write", 32'(w2_cnt), 32'(w2_before + 1));
        evt_ready = 1'b1;
        tick();
        chk("fifo_flushed", 32'(evt_valid), 32'(0));
`endif
        stim_done = 1'b1;
      end
      begin : mon
        logic [7:0] exp;
        while (!stim_done) begin
          @(negedge clk);
          if (reset_n) begin
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2) begin
              w2_cnt++;
              last_w2 = avm_writedata;
            end
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3) w3_cnt++;
            if (avm_chipselect && avm_write_n && avm_address == 2'd3) r3_cnt++;
            if (evt_valid && evt_ready) begin
              if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=0x%0h required=none", evt_data);
              end else begin
                exp = exp_q.pop_front();
                chk("evt_data", 32'(evt_data), 32'(exp));
              end
            end
          end
        end
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
